// File: rtl/iter_divider.sv
// iter_divider: multi-cycle radix-2 restoring divider for signed/unsigned DIV and MOD
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             complete
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  state_t           r_state, w_next;
  logic             r_sgn, r_complete;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_mag_a, r_mag_b, r_rem, r_quo, r_rmd;
  logic [CW-1:0]    r_cnt;
  logic             w_same, w_start, w_zero, w_last, w_ge, w_neg_q, w_neg_r;
  logic [WIDTH:0]   w_top;
  logic [WIDTH-1:0] w_diff;
  assign w_same  = {is_signed, dividend, divisor} == {r_sgn, r_dvd, r_dvs};
  assign w_start = en && (r_state == IDLE || (r_state == DONE && !w_same));
  assign w_zero  = divisor == '0;
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  assign w_top   = {r_rem, r_mag_a[WIDTH-1]};
  assign w_ge    = w_top >= {1'b0, r_mag_b};
  assign w_diff  = w_top[WIDTH-1:0] - r_mag_b;
  assign w_neg_q = r_sgn && (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
  assign w_neg_r = r_sgn && r_dvd[WIDTH-1];
  assign quotient  = r_quo;
  assign remainder = r_rmd;
  assign complete  = r_complete;
  // next state: a new or differing request restarts, en low always returns to idle
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_start ? (w_zero ? DONE : BUSY) : IDLE;
      BUSY:    w_next = !en ? IDLE : (w_last ? FIX : BUSY);
      FIX:     w_next = en ? DONE : IDLE;
      DONE:    w_next = !en ? IDLE : (w_start ? (w_zero ? DONE : BUSY) : DONE);
      default: w_next = IDLE;
    endcase
  end
  // state register and registered completion flag, high exactly while in DONE
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_complete <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_complete <= w_next == DONE;
    end
  end
  // datapath: latch request, iterate shift/subtract, then sign-correct into outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_sgn   <= 1'b0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
    end else if (w_start) begin
      r_sgn   <= is_signed;
      r_dvd   <= dividend;
      r_dvs   <= divisor;
      r_mag_a <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      r_mag_b <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
      r_rem   <= '0;
      r_cnt   <= '0;
      if (w_zero) begin
        r_quo <= '1;
        r_rmd <= dividend;
      end
    end else if (r_state == BUSY && en) begin
      r_rem   <= w_ge ? w_diff : w_top[WIDTH-1:0];
      r_mag_a <= {r_mag_a[WIDTH-2:0], w_ge};
      r_cnt   <= r_cnt + 1'b1;
    end else if (r_state == FIX && en) begin
      r_quo <= w_neg_q ? -r_mag_a : r_mag_a;
      r_rmd <= w_neg_r ? -r_rem : r_rem;
    end
  end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: table-driven and scoreboard checks for iter_divider
module tb_iter_divider;
  logic        aclk = 0, aresetn = 0, en = 0, is_signed = 0;
  logic [31:0] dividend = 0, divisor = 0, quotient, remainder;
  logic        complete;
  int          checks = 0, errors = 0;
  typedef struct {logic [31:0] q, r; int edges;} exp_t;
  typedef struct {bit s; logic [31:0] a, b, q, r; int edges;} vec_t;
  exp_t        sb[$];
  vec_t        vt[$];
  logic [31:0] last_q = 0, last_r = 0;

  always #5 aclk = ~aclk;

  iter_divider #(.WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .complete(complete)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sd;
    sa = a;
    sd = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 0;
    end else begin
      q = sa / sd;
      r = sa % sd;
    end
  endfunction

  task automatic start(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input int edges);
    @(negedge aclk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    en        = 1;
    sb.push_back('{q, r, edges});
  endtask

  task automatic collect(input int chg_at, input logic [31:0] new_a);
    int   n = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && n < 200) begin
      @(posedge aclk);
      @(negedge aclk);
      n++;
      seen = complete;
      if (n == chg_at) dividend = new_a;
    end
    e = sb.pop_front();
    chk("latency", n, e.edges);
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    last_q = e.q;
    last_r = e.r;
  endtask

  initial begin
    int          hits;
    logic [31:0] ra, rb, rq, rr;
    vt.push_back('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34});
    vt.push_back('{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34});
    vt.push_back('{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34});
    vt.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34});
    vt.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34});
    vt.push_back('{1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1});
    vt.push_back('{1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1});
    vt.push_back('{1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1});
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 100000);
      if (i[0]) rb = -rb;
      model(i < 2, ra, rb, rq, rr);
      vt.push_back('{i < 2, ra, rb, rq, rr, 34});
    end
    #12;
    chk("reset_complete", complete, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    @(negedge aclk);
    aresetn = 1;
    foreach (vt[i]) begin
      start(vt[i].s, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].edges);
      collect(0, 0);
      repeat (2) @(negedge aclk);
      chk("hold_complete", complete, 1);
      chk("hold_quotient", quotient, vt[i].q);
      en = 0;
      @(negedge aclk);
      chk("drop_complete", complete, 0);
    end
    @(negedge aclk);
    is_signed = 0;
    dividend  = 1000;
    divisor   = 3;
    en        = 1;
    repeat (10) @(negedge aclk);
    en   = 0;
    hits = 0;
    repeat (40) begin
      @(negedge aclk);
      if (complete) hits++;
    end
    chk("abort_complete", hits, 0);
    chk("abort_quotient", quotient, last_q);
    chk("abort_remainder", remainder, last_r);
    start(0, 32'd1000, 32'd3, 32'd333, 32'd1, 34);
    sb.push_back('{32'd16, 32'd2, 34});
    collect(5, 32'd50);
    collect(0, 0);
    en = 0;
    @(negedge aclk);
    @(negedge aclk);
    is_signed = 0;
    dividend  = 1000;
    divisor   = 3;
    en        = 1;
    repeat (20) @(negedge aclk);
    aresetn = 0;
    #1;
    chk("midreset_complete", complete, 0);
    chk("midreset_quotient", quotient, 0);
    chk("midreset_remainder", remainder, 0);
    en = 0;
    @(negedge aclk);
    aresetn = 1;
    start(0, 32'd9, 32'd3, 32'd3, 32'd0, 34);
    collect(0, 0);
    en = 0;
    @(negedge aclk);
    chk("final_drop_complete", complete, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
